// File: rtl/cdc_handshake_src.sv
// Source-domain half of a two-phase (toggle) multi-bit handshake crossing.
// Holds an accepted word on data_out, toggles req_tgl, and waits for the synchronized ack toggle.
module cdc_handshake_src #(
  parameter int WIDTH   = 32,
  parameter int N_STAGE = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             req_tgl,
  input  logic             ack_tgl,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  (* ASYNC_REG = "TRUE" *) logic [N_STAGE-1:0] ack_s;
  logic ack_sync;
  logic accept;
  logic complete;
  logic err_set;
  logic init_clear;

  // ack synchronizer: ack_s[0] is the only flop that sees the asynchronous input
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_s <= '0;
    end else begin
      ack_s <= {ack_s[N_STAGE-2:0], ack_tgl};
    end
  end

  assign ack_sync = ack_s[N_STAGE-1];

  // Leaving INIT needs the destination's ack level to agree with req_tgl at the pin and
  // across every synchronizer stage, so a stale ack still draining cannot open IDLE.
  assign init_clear = (ack_s == {N_STAGE{req_tgl}}) && (ack_tgl == req_tgl);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (init_clear) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (din_valid) begin
          accept  = 1'b1;
          state_d = ST_WAIT_ACK;
        end else if (ack_sync != req_tgl) begin
          err_set = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_sync == req_tgl) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // state, held word and request toggle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      data_out  <= '0;
      req_tgl   <= 1'b0;
      xfer_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_out <= din;
        req_tgl  <= ~req_tgl;
      end
      if (complete) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      if (err_set) begin
        proto_err <= 1'b1;
      end
    end
  end

  assign din_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_WAIT_ACK);

endmodule
